// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl: valid/ready control stage in front of the 8x9 FIFO storage block.
// Latency: write strobe same cycle as accept; rden in cycle t gives out_valid from t+2; flush takes 2 cycles.
// Backpressure: in_ready low when storage full or outside RUN; out_data held while out_valid && !out_ready.
// Optional feature macro FIFO8X9_CTRL_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module fifo8x9_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = 9,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wren,
  output logic          fifo_wrinc,
  output logic          fifo_rden,
  output logic          fifo_rdinc,
  output logic          fifo_wrptrclr,
  output logic          fifo_rdptrclr,
  input  logic [DW-1:0] fifo_dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
`ifdef FIFO8X9_CTRL_DROP_CNT_EN
  , output logic [7:0]  drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {INIT, RUN, FLUSH, CLR} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          rd_pend;
  logic          wr_go;
  logic          rd_go;
  logic          clearing;

  // Next state and handshake decode; reads and writes only happen in RUN.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    case (state)
      INIT:  state_nxt = RUN;
      RUN: begin
        in_ready = (count != CW'(DEPTH));
        wr_go    = in_valid && in_ready;
        rd_go    = (count != '0) && !rd_pend && (!out_valid || out_ready);
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = CLR;
      CLR:   state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign clearing   = (state == FLUSH) || (state == CLR);
  assign fifo_din   = in_data;
  assign fifo_wren  = wr_go;
  assign fifo_wrinc = wr_go;
  assign fifo_rden  = rd_go;
  assign fifo_rdinc = rd_go;
  // The INIT clear is gated by rst so the strobes stay quiet while reset is held.
  // A clear on the last entry overrides the storage increment, wrapping its pointer to 0.
  assign fifo_wrptrclr = (rst && state == INIT) || (state == CLR) ||
                         (wr_go && wr_idx == AW'(DEPTH - 1));
  assign fifo_rdptrclr = (rst && state == INIT) || (state == CLR) ||
                         (rd_go && rd_idx == AW'(DEPTH - 1));
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  // Occupancy, shadow pointers and read-pending flag; wiped while flushing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      rd_pend <= 1'b0;
    end else if (clearing) begin
      count   <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (wr_go) wr_idx <= wr_idx + AW'(1);
      if (rd_go) rd_idx <= rd_idx + AW'(1);
      case ({wr_go, rd_go})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rd_pend <= rd_go;
    end
  end

  // Output register: capture storage data the cycle after rden; a flush discards the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (rd_pend) out_data <= fifo_dout;
      if (clearing)                     out_valid <= 1'b0;
      else if (rd_pend)                 out_valid <= 1'b1;
      else if (out_valid && out_ready)  out_valid <= 1'b0;
    end
  end

`ifdef FIFO8X9_CTRL_DROP_CNT_EN
  // Count RUN cycles where the producer is stalled; saturates, cleared in CLR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (state == CLR) begin
      drop_cnt <= '0;
    end else if (state == RUN && in_valid && !in_ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: storage-block emulator plus queue-based reference model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Optional drop counter checks compile in with FIFO8X9_CTRL_DROP_CNT_EN.
module tb_fifo8x9_ctrl;
  localparam int DEPTH = 8;
  localparam int DW    = 9;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data, fifo_din;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_wren, fifo_wrinc, fifo_rden, fifo_rdinc, fifo_wrptrclr, fifo_rdptrclr;
  logic [CW-1:0] count;
  logic          full, empty;
`ifdef FIFO8X9_CTRL_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  fifo8x9_ctrl #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .fifo_din(fifo_din), .fifo_wren(fifo_wren), .fifo_wrinc(fifo_wrinc),
    .fifo_rden(fifo_rden), .fifo_rdinc(fifo_rdinc), .fifo_wrptrclr(fifo_wrptrclr),
    .fifo_rdptrclr(fifo_rdptrclr), .fifo_dout(fifo_dout), .count(count),
    .full(full), .empty(empty)
`ifdef FIFO8X9_CTRL_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Storage block emulator; pointers start off-zero so a missing INIT clear corrupts data.
  logic [DW-1:0] mem [DEPTH];
  logic [2:0]    s_wp = 3'd3;
  logic [2:0]    s_rp = 3'd6;
  always @(posedge clk) begin
    if (fifo_wren) mem[s_wp] <= fifo_din;
    fifo_dout <= fifo_rden ? mem[s_rp] : DW'($urandom);
    s_wp <= fifo_wrptrclr ? 3'd0 : (fifo_wrinc ? s_wp + 3'd1 : s_wp);
    s_rp <= fifo_rdptrclr ? 3'd0 : (fifo_rdinc ? s_rp + 3'd1 : s_rp);
  end

  // Reference model: phase 0=INIT 1=RUN 2=FLUSH 3=CLR.
  int            m_phase;
  logic [DW-1:0] mq[$];
  bit            m_pend;
  logic [DW-1:0] m_pword;
  logic [DW-1:0] m_od;
  bit            m_ov;
  int            m_wrn, m_rdn, m_drop;
  logic [DW-1:0] rxq[$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; mq.delete(); m_pend = 0; m_pword = '0; m_od = '0; m_ov = 0;
    m_wrn = 0; m_rdn = 0; m_drop = 0;
  endtask

  task automatic tick();
    bit run, e_rdy, e_wr, e_rd, e_wc, e_rc;
    @(negedge clk);
    if (!rst) model_reset();
    run   = rst && (m_phase == 1);
    e_rdy = run && (mq.size() != DEPTH);
    e_wr  = e_rdy && in_valid;
    e_rd  = run && (mq.size() != 0) && !m_pend && (!m_ov || out_ready);
    e_wc  = rst && (m_phase == 0 || m_phase == 3 || (e_wr && m_wrn == DEPTH - 1));
    e_rc  = rst && (m_phase == 0 || m_phase == 3 || (e_rd && m_rdn == DEPTH - 1));
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("fifo_wren", 32'(fifo_wren), 32'(e_wr));
    chk("fifo_wrinc", 32'(fifo_wrinc), 32'(e_wr));
    chk("fifo_rden", 32'(fifo_rden), 32'(e_rd));
    chk("fifo_rdinc", 32'(fifo_rdinc), 32'(e_rd));
    chk("fifo_wrptrclr", 32'(fifo_wrptrclr), 32'(e_wc));
    chk("fifo_rdptrclr", 32'(fifo_rdptrclr), 32'(e_rc));
    chk("fifo_din", 32'(fifo_din), 32'(in_data));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
`ifdef FIFO8X9_CTRL_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    if (rst) begin
      if (out_valid && out_ready) rxq.push_back(out_data);
      if (m_phase == 3) m_drop = 0;
      else if (run && in_valid && !e_rdy && m_drop < 255) m_drop++;
      if (m_pend) m_od = m_pword;
      if (m_phase == 2 || m_phase == 3) m_ov = 0;
      else if (m_pend) m_ov = 1;
      else if (m_ov && out_ready) m_ov = 0;
      m_pend = e_rd;
      if (e_rd) begin m_pword = mq.pop_front(); m_rdn = (m_rdn + 1) % DEPTH; end
      if (e_wr) begin mq.push_back(in_data); m_wrn = (m_wrn + 1) % DEPTH; end
      if (m_phase == 2 || m_phase == 3) begin
        mq.delete(); m_pend = 0; m_wrn = 0; m_rdn = 0;
      end
      case (m_phase)
        0:       m_phase = 1;
        1:       m_phase = flush ? 2 : 1;
        2:       m_phase = 3;
        default: m_phase = 1;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = DW'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    int acc, guard, maxc;
    model_reset();
    // Reset held, then release into INIT.
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wrptrclr", 32'(fifo_wrptrclr), 32'd0);
    rst = 1'b1;
    #1;
    chk("init_wrptrclr", 32'(fifo_wrptrclr), 32'd1);
    chk("init_rdptrclr", 32'(fifo_rdptrclr), 32'd1);
    tick();
    chk("init_once", 32'(fifo_wrptrclr), 32'd0);
    chk("run_in_ready", 32'(in_ready), 32'd1);
    chk("run_empty", 32'(empty), 32'd1);

    // Fill with out_ready low: first word moves to out_data, 8 more fill storage.
    rxq.delete();
    push_words(9, 1);
    repeat (3) tick();
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    chk("fill_out_data", 32'(out_data), 32'd1);
    in_valid = 1'b1; in_data = 9'h00A;
    chk("fill_blocked", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    repeat (25) tick();
    chk("drain_n", 32'(rxq.size()), 32'd9);
    for (int i = 0; i < rxq.size() && i < 9; i++) chk("drain_word", 32'(rxq[i]), 32'(i + 1));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Streaming 20 words through with both sides active.
    rxq.delete(); acc = 0; guard = 0; maxc = 0;
    while (acc < 20 && guard < 200) begin
      in_valid = 1'b1; in_data = DW'(9'h100 + acc);
      if (in_ready) acc++;
      if (int'(count) > maxc) maxc = int'(count);
      tick(); guard++;
    end
    in_valid = 1'b0;
    repeat (30) tick();
    chk("stream_n", 32'(rxq.size()), 32'd20);
    for (int i = 0; i < rxq.size() && i < 20; i++) chk("stream_word", 32'(rxq[i]), 32'(9'h100 + i));
    chk("stream_maxc", 32'(maxc <= DEPTH), 32'd1);

    // Flush with 5 words loaded.
    out_ready = 1'b0;
    push_words(5, 9'h050);
    repeat (3) tick();
    chk("pre_flush_ov", 32'(out_valid), 32'd1);
    chk("pre_flush_count", 32'(count), 32'd4);
    pulse_flush();
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_wrptrclr", 32'(fifo_wrptrclr), 32'd1);
    chk("clr_rdptrclr", 32'(fifo_rdptrclr), 32'd1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("post_flush_ready", 32'(in_ready), 32'd1);
    rxq.delete();
    push_words(1, 9'h1AA);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("flush_rd_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("flush_rd_word", 32'(rxq[0]), 32'h1AA);

`ifdef FIFO8X9_CTRL_DROP_CNT_EN
    // Saturate the drop counter, then clear it with a flush.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 310; i++) begin in_data = DW'($urandom); tick(); end
    in_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    pulse_flush();
    repeat (3) tick();
    chk("drop_clr", 32'(drop_cnt), 32'd0);
`endif

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 2) != 0);
      in_data   = DW'($urandom);
      out_ready = 1'($urandom_range(0, 2) == 0);
      flush     = 1'($urandom_range(0, 60) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (25) tick();

    // Reset mid-operation with 4 words in storage.
    out_ready = 1'b0;
    push_words(5, 9'h0C0);
    repeat (2) tick();
    chk("mid_count", 32'(count), 32'd4);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_od", 32'(out_data), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rxq.delete();
    push_words(1, 9'h0F0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("mid_rd_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("mid_rd_word", 32'(rxq[0]), 32'h0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
